// File: rtl/fdct8.sv
// 8-point 1-D forward DCT, coefficients scaled by 256, 4-stage pipeline with a
// global stall: every stage advances together when the output is free or being taken.

module fdct8_bfly (
  input  logic [31:0] x_lo,
  input  logic [31:0] x_hi,
  output logic [31:0] sum,
  output logic [31:0] diff
);
  assign sum  = x_lo + x_hi;
  assign diff = x_lo - x_hi;
endmodule

module fdct8 (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [255:0] data_in,
  input  logic [4:0]   shift_amount,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [255:0] data_out
);
  localparam int STAGES = 4;
  typedef logic [31:0] word_t;

  localparam word_t C1 = 32'd251;
  localparam word_t C2 = 32'd237;
  localparam word_t C3 = 32'd213;
  localparam word_t C4 = 32'd181;
  localparam word_t C5 = 32'd142;
  localparam word_t C6 = 32'd98;
  localparam word_t C7 = 32'd50;

  logic                adv;
  logic [STAGES:1]     vld_q, vld_d;
  logic [STAGES:0]     vld_pipe;
  logic [STAGES:1]     en;

  word_t [7:0]         x;
  word_t [3:0]         a_c, b_c, e_c;
  word_t [3:0]         a_q, a_d, b1_q, b1_d;
  word_t [3:0]         e_q, e_d, b2_q, b2_d;
  word_t [5:0]         pe_q, pe_d;
  word_t [3:0][3:0]    po_q, po_d;
  word_t [7:0]         y;
  word_t [7:0]         dout_q, dout_d;
  logic  [4:0]         sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
  word_t [3:0]         codd;

  assign adv      = !vld_q[STAGES] | m_ready;
  assign s_ready  = adv;
  assign m_valid  = vld_q[STAGES];
  assign data_out = dout_q;
  assign x        = data_in;
  assign vld_pipe = {vld_q, s_valid};
  assign codd     = {C7, C5, C3, C1};

  // Each stage loads only when a valid beat arrives into it, so bubbles leave data untouched.
  always_comb begin
    for (int i = 1; i <= STAGES; i++) en[i] = adv & vld_pipe[i-1];
    vld_d = adv ? vld_pipe[STAGES-1:0] : vld_q;
  end

  genvar n;
  generate
    for (n = 0; n < 4; n++) begin : g_s1
      fdct8_bfly u_bfly (.x_lo(x[n]), .x_hi(x[7-n]), .sum(a_c[n]), .diff(b_c[n]));
    end
  endgenerate

  fdct8_bfly u_e03 (.x_lo(a_q[0]), .x_hi(a_q[3]), .sum(e_c[0]), .diff(e_c[3]));
  fdct8_bfly u_e12 (.x_lo(a_q[1]), .x_hi(a_q[2]), .sum(e_c[1]), .diff(e_c[2]));

  always_comb begin
    a_d   = en[1] ? a_c : a_q;
    b1_d  = en[1] ? b_c : b1_q;
    sh1_d = en[1] ? shift_amount : sh1_q;

    e_d   = en[2] ? e_c : e_q;
    b2_d  = en[2] ? b1_q : b2_q;
    sh2_d = en[2] ? sh1_q : sh2_q;

    pe_d  = pe_q;
    po_d  = po_q;
    sh3_d = en[3] ? sh2_q : sh3_q;
    if (en[3]) begin
      pe_d[0] = C4 * (e_q[0] + e_q[1]);
      pe_d[1] = C4 * (e_q[0] - e_q[1]);
      pe_d[2] = C2 * e_q[3];
      pe_d[3] = C6 * e_q[2];
      pe_d[4] = C6 * e_q[3];
      pe_d[5] = C2 * e_q[2];
      // po[k][j] = odd coefficient k (C1,C3,C5,C7) times b[j]
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < 4; j++)
          po_d[k][j] = codd[k] * b2_q[j];
    end
  end

  always_comb begin
    y[0] = pe_q[0];
    y[4] = pe_q[1];
    y[2] = pe_q[2] + pe_q[3];
    y[6] = pe_q[4] - pe_q[5];
    y[1] = po_q[0][0] + po_q[1][1] + po_q[2][2] + po_q[3][3];
    y[3] = po_q[1][0] - po_q[3][1] - po_q[0][2] - po_q[2][3];
    y[5] = po_q[2][0] - po_q[0][1] + po_q[3][2] + po_q[1][3];
    y[7] = po_q[3][0] - po_q[2][1] + po_q[1][2] - po_q[0][3];
    dout_d = dout_q;
    if (en[4])
      for (int k = 0; k < 8; k++) dout_d[k] = word_t'($signed(y[k]) >>> sh3_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      a_q    <= '0;
      b1_q   <= '0;
      sh1_q  <= '0;
      e_q    <= '0;
      b2_q   <= '0;
      sh2_q  <= '0;
      pe_q   <= '0;
      po_q   <= '0;
      sh3_q  <= '0;
      dout_q <= '0;
    end else begin
      vld_q  <= vld_d;
      a_q    <= a_d;
      b1_q   <= b1_d;
      sh1_q  <= sh1_d;
      e_q    <= e_d;
      b2_q   <= b2_d;
      sh2_q  <= sh2_d;
      pe_q   <= pe_d;
      po_q   <= po_d;
      sh3_q  <= sh3_d;
      dout_q <= dout_d;
    end
  end
endmodule

// File: tb/tb_fdct8.sv
// Directed bench for fdct8: hand-computed coefficient vectors, latency, stall,
// per-beat shift and mid-stream reset; outputs scored in order from a queue.

module tb_fdct8;
  logic         clk = 1'b0;
  logic         rst, s_valid, s_ready, m_valid, m_ready;
  logic [255:0] data_in, data_out;
  logic [4:0]   shift_amount;

  int n_vec = 0, n_bad = 0, n_got = 0, n_exp = 0;
  logic [255:0] expq[$];

  always #5 clk = ~clk;

  fdct8 dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .data_in(data_in), .shift_amount(shift_amount),
    .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic [255:0] pk(input int v[8]);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = v[i];
    return r;
  endfunction

  function automatic logic [255:0] all8(input int v);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = v;
    return r;
  endfunction

  task automatic send(input logic [255:0] d, input logic [4:0] sh, input logic [255:0] e);
    int   t = 0;
    logic acc;
    expq.push_back(e);
    n_exp++;
    s_valid = 1'b1;
    data_in = d;
    shift_amount = sh;
    forever begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 40) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", expq.size(), 0);
  endtask

  always @(negedge clk) begin : mon
    logic [255:0] e;
    if (!rst && m_valid && m_ready) begin
      if (expq.size() == 0) chk("extra_beat", 1, 0);
      else begin
        e = expq.pop_front();
        n_got++;
        for (int k = 0; k < 8; k++)
          chk($sformatf("beat%0d_X%0d", n_got, k), data_out[32*k +: 32], e[32*k +: 32]);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   bp_x0[6];
    logic [31:0] held;
    bp_x0 = '{282, 565, 848, 1131, 1414, 1696};
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1; data_in = '0; shift_amount = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mvalid", m_valid, 0);
    chk("rst_dout", {31'd0, |data_out}, 0);
    chk("rst_sready", s_ready, 1);

    // DC with latency check
    send(all8(100), 9, pk('{282, 0, 0, 0, 0, 0, 0, 0}));
    repeat (2) @(posedge clk);
    #1 chk("lat3_mvalid", m_valid, 0);
    @(posedge clk);
    #1 chk("lat4_mvalid", m_valid, 1);
    drain();

    // Coefficient patterns, back to back
    send(pk('{256, 0, 0, 0, 0, 0, 0, 0}), 8, pk('{181, 251, 237, 213, 181, 142, 98, 50}));
    send(pk('{-256, 0, 0, 0, 0, 0, 0, 0}), 8, pk('{-181, -251, -237, -213, -181, -142, -98, -50}));
    send(all8(-1), 9, pk('{-3, 0, 0, 0, 0, 0, 0, 0}));
    send(pk('{0, 256, 0, 0, 0, 0, 0, 0}), 8, pk('{181, 213, 98, -50, -181, -251, -237, -142}));
    send(pk('{0, 1, 2, 3, 4, 5, 6, 7}), 0, pk('{5068, -3298, 0, -346, 0, -102, 0, -28}));
    drain();

    // Per-beat shift
    send(pk('{256, 0, 0, 0, 0, 0, 0, 0}), 8, pk('{181, 251, 237, 213, 181, 142, 98, 50}));
    send(pk('{256, 0, 0, 0, 0, 0, 0, 0}), 9, pk('{90, 125, 118, 106, 90, 71, 49, 25}));
    send(pk('{256, 0, 0, 0, 0, 0, 0, 0}), 10, pk('{45, 62, 59, 53, 45, 35, 24, 12}));
    shift_amount = 5'd0;
    drain();

    // Backpressure mid-burst
    fork
      begin
        for (int k = 0; k < 6; k++)
          send(all8(100 * (k + 1)), 9, pk('{bp_x0[k], 0, 0, 0, 0, 0, 0, 0}));
      end
      begin
        repeat (5) @(posedge clk);
        #1 m_ready = 1'b0;
        held = data_out[31:0];
        repeat (3) begin
          @(negedge clk);
          chk("stall_sready", s_ready, 0);
          chk("stall_mvalid", m_valid, 1);
          chk("stall_hold", data_out[31:0], held);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight
    for (int k = 0; k < 3; k++)
      send(pk('{256, 0, 0, 0, 0, 0, 0, 0}), 8, pk('{181, 251, 237, 213, 181, 142, 98, 50}));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_exp -= expq.size();
    expq.delete();
    chk("midrst_mvalid", m_valid, 0);
    chk("midrst_dout", {31'd0, |data_out}, 0);
    repeat (6) begin
      @(negedge clk);
      chk("no_stale", m_valid, 0);
    end
    @(posedge clk);
    #1;
    send(all8(100), 9, pk('{282, 0, 0, 0, 0, 0, 0, 0}));
    repeat (2) @(posedge clk);
    #1 chk("post_rst_lat3", m_valid, 0);
    @(posedge clk);
    #1 chk("post_rst_lat4", m_valid, 1);
    drain();

    chk("count", n_got, n_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
